// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweep/capture harness stage.
package tt_sweep_pkg;

    localparam int unsigned TT_W   = 16;
    localparam int unsigned NUM_IN = 4;

    typedef logic [TT_W-1:0]   tt_t;
    typedef logic [NUM_IN-1:0] minterm_t;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StSample,
        StDone
    } state_e;

    localparam tt_t TT_AND4 = 16'h8000;
    localparam tt_t TT_XOR4 = 16'h6996;
    localparam tt_t TT_OR4  = 16'hFFFE;

endpackage

// File: rtl/tt_sweep_cmp.sv
// Combinational comparison of a captured truth table against the expected one.
// TT_SWEEP_NPN_OUTNEG_EN adds the output-negation equivalence flag match_neg_o.
module tt_sweep_cmp
    import tt_sweep_pkg::*;
(
    input  logic [TT_W-1:0] tt_i,
    input  logic [TT_W-1:0] exp_i,
    output logic            match_o,
`ifdef TT_SWEEP_NPN_OUTNEG_EN
    output logic            match_neg_o,
`endif
    output logic [TT_W-1:0] diff_o
);

    always_comb begin
        match_o = (tt_i == exp_i);
        diff_o  = tt_i ^ exp_i;
`ifdef TT_SWEEP_NPN_OUTNEG_EN
        match_neg_o = (tt_i == ~exp_i);
`endif
    end

endmodule

// File: rtl/tt_sweep_capture.sv
// Sweeps x through all 16 minterms, samples y after SETTLE_CYCLES, captures and checks the table.
// TT_SWEEP_NPN_OUTNEG_EN adds the match_neg_o output (tt == ~expected).
module tt_sweep_capture
    import tt_sweep_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [TT_W-1:0]   exp_tt_i,
    output logic [NUM_IN-1:0] x_o,
    input  logic              y_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [TT_W-1:0]   tt_o,
    output logic              match_o,
`ifdef TT_SWEEP_NPN_OUTNEG_EN
    output logic              match_neg_o,
`endif
    output logic [TT_W-1:0]   diff_o
);

    localparam logic [3:0] SettleLd = 4'(SETTLE_CYCLES);
    localparam state_e     StAfterLoad = (SETTLE_CYCLES == 0) ? StSample : StWait;

    state_e   state_q;
    minterm_t idx_q;
    logic [3:0] cnt_q;
    tt_t      exp_q;
    tt_t      tt_q;
    tt_t      diff_q;
    logic     busy_q;
    logic     done_q;
    logic     match_q;

    tt_t      tt_smp;
    tt_t      cmp_diff;
    logic     cmp_match;

    // Table as it will look after this cycle's sample, so DONE-entry flags see the last bit.
    always_comb begin
        tt_smp        = tt_q;
        tt_smp[idx_q] = y_i;
    end

`ifdef TT_SWEEP_NPN_OUTNEG_EN
    logic match_neg_q;
    logic cmp_match_neg;

    tt_sweep_cmp u_cmp (
        .tt_i        (tt_smp),
        .exp_i       (exp_q),
        .match_o     (cmp_match),
        .match_neg_o (cmp_match_neg),
        .diff_o      (cmp_diff)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_neg_q <= 1'b0;
        end else if ((state_q == StIdle || state_q == StDone) && start_i) begin
            match_neg_q <= 1'b0;
        end else if (state_q == StSample && idx_q == 4'd15) begin
            match_neg_q <= cmp_match_neg;
        end
    end

    assign match_neg_o = match_neg_q;
`else
    tt_sweep_cmp u_cmp (
        .tt_i    (tt_smp),
        .exp_i   (exp_q),
        .match_o (cmp_match),
        .diff_o  (cmp_diff)
    );
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            cnt_q   <= '0;
            exp_q   <= '0;
            tt_q    <= '0;
            diff_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (start_i) begin
                        exp_q   <= exp_tt_i;
                        tt_q    <= '0;
                        match_q <= 1'b0;
                        diff_q  <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        cnt_q   <= SettleLd;
                        state_q <= StAfterLoad;
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= StSample;
                    end
                end
                StSample: begin
                    tt_q <= tt_smp;
                    if (idx_q == 4'd15) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        match_q <= cmp_match;
                        diff_q  <= cmp_diff;
                    end else begin
                        idx_q   <= idx_q + 4'd1;
                        cnt_q   <= SettleLd;
                        state_q <= StAfterLoad;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign x_o     = idx_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign tt_o    = tt_q;
    assign match_o = match_q;
    assign diff_o  = diff_q;

endmodule

// File: doc/tt_sweep_capture.md
Name: tt_sweep_capture

Overview:
- Upstream/downstream harness stage for the 4-input single-output exact AIG netlists.
- Drives the combinational netlist's inputs x0..x3 through all 16 minterms, samples y0 after a programmable settle time, and assembles a 16-bit truth table.
- Compares the captured truth table against an expected table.
- Used to check each synthesized NPN-class AIG against its target function in-system.

Parameters:
- SETTLE_CYCLES, 1, idle cycles between driving a minterm and sampling y; legal range 0..15.
- TT_W, 16, truth-table width; fixed at 2^4, not user-overridable.

Ports:
- clk  input  1  single clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE or DONE
- exp_tt  input  16  expected truth table, bit i = f(x3..x0 = i); latched on accepted start
- x  output  4  minterm driven to the netlist (x[0] = x0 ... x[3] = x3)
- y  input  1  netlist output y0
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle pulse when the sweep completes
- tt  output  16  captured truth table; held after done until the next accepted start
- match  output  1  tt == exp_tt; valid while in DONE
- diff  output  16  tt XOR exp_tt; valid while in DONE

Behaviour:
- Reset (async, immediate): state = IDLE. x = 0, busy = 0, done = 0, tt = 0, match = 0, diff = 0. Minterm index = 0, settle counter = 0. Latched expected table = 0.
- States: IDLE, WAIT, SAMPLE, DONE.
- IDLE/DONE with start = 1:
  - latch exp_tt; clear tt, match, diff; set index = 0 and x = 0; busy = 1.
  - Go to WAIT with counter = SETTLE_CYCLES, or directly to SAMPLE if SETTLE_CYCLES = 0.
- WAIT: decrement counter each cycle; go to SAMPLE when counter reaches 1. WAIT lasts exactly SETTLE_CYCLES cycles.
- SAMPLE: write y into tt[index].
  - If index == 15: go to DONE.
  - Otherwise: index++, x = index+1 (registered, changes the following cycle), counter reloads, go to WAIT (or stay in SAMPLE if SETTLE_CYCLES = 0).
- DONE entry cycle:
  - done = 1 for exactly one cycle; busy = 0.
  - match and diff are computed from the completed tt and registered; they are valid from the first DONE cycle.
- DONE: hold x, tt, match and diff until an accepted start.
- x is registered and changes only on minterm advance or start; it stays glitch-free during WAIT.
- Latency:
  - Each minterm occupies SETTLE_CYCLES+1 cycles.
  - done rises 16*(SETTLE_CYCLES+1)+1 cycles after the start edge. SETTLE_CYCLES = 1 gives 33.
- start while busy (WAIT/SAMPLE): ignored, no restart, and exp_tt is not re-latched.
- start in the same cycle done pulses (in DONE): accepted. done still pulses that cycle; the new sweep begins the next cycle.
- exp_tt changes mid-sweep: no effect, the latched copy is used.
- rst mid-sweep: immediate abort to reset values; no done pulse.
- Index wrap: never wraps. 15 is terminal.

Optional Feature:
- Macro: TT_SWEEP_NPN_OUTNEG_EN.
- Defined:
  - adds output port match_neg (1 bit), asserted in DONE when tt == ~exp_tt (output-negation NPN equivalent).
  - diff is unchanged.
  - match_neg resets to 0 and clears on accepted start.
- Undefined: port absent, no extra logic. All other behaviour is identical.

Decomposition:
- Shared package tt_sweep_pkg:
  - state enum (IDLE, WAIT, SAMPLE, DONE)
  - TT_W = 16, NUM_IN = 4
  - typedef tt_t = logic[15:0], minterm_t = logic[3:0]
  - reference constants TT_AND4 = 16'h8000, TT_XOR4 = 16'h6996, TT_OR4 = 16'hFFFE
- One natural sub-module: tt_sweep_cmp, the combinational comparator producing match, diff and (optionally) match_neg from tt and the latched expected table. The top level registers its outputs on DONE entry.

Test Plan:
- Reset value check:
  - stimulus: assert rst mid-cycle.
  - response: all outputs 0 immediately; state IDLE.
- AND4 sweep:
  - stimulus: y = &x model, exp_tt = 16'h8000, SETTLE_CYCLES = 1, pulse start.
  - response: x steps 0..15, each held 2 cycles; done 33 cycles after start; tt = 16'h8000; match = 1; diff = 0.
- XOR4 sweep with one mismatch:
  - stimulus: y = ^x model with y forced wrong at x = 5, exp_tt = 16'h6996.
  - response: tt = 16'h69B6; match = 0; diff = 16'h0020.
- SETTLE_CYCLES = 0 variant:
  - stimulus: OR4 model, exp_tt = 16'hFFFE.
  - response: done 17 cycles after start; match = 1.
- Start/reset during sweep:
  - stimulus: start pulsed at cycle 10 of a sweep, then rst at cycle 20.
  - response: the cycle-10 start is ignored (x sequence unbroken); rst returns x = 0, busy = 0, no done pulse. A subsequent start runs a full clean sweep.
- Output-negation match (TT_SWEEP_NPN_OUTNEG_EN defined):
  - stimulus: NAND4 model, exp_tt = 16'h8000.
  - response: tt = 16'h7FFF; match = 0; match_neg = 1.
